// File: rtl/vram_scheduler_pkg.sv
// Slot constants, palette-write FSM states and window helpers shared by the
// VRAM scheduler and its palette-write buffer.
package vram_scheduler_pkg;

    localparam int CELL_LEN  = 32;
    localparam int FETCH_LEN = 4;
    localparam int BMP_SLOT  = 0;
    localparam int ATR_SLOT  = 4;
    localparam int UP_SLOT   = 8;
    localparam int UPW_LEN   = 2;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        UPW_IDLE,
        UPW_PEND,
        UPW_WRITE
    } upw_state_t;

    function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int start);
        return (int'(cnt) >= start) && (int'(cnt) < start + FETCH_LEN);
    endfunction

    function automatic logic is_last(input logic [CNT_W-1:0] cnt, input int start);
        return int'(cnt) == start + FETCH_LEN - 1;
    endfunction

endpackage

// File: rtl/vram_upw_buffer.sv
// Single-entry ULA+ palette write buffer: holds one write until a free SRAM
// slot appears, yields to any fetch window and retries the write in full.
module vram_upw_buffer
    import vram_scheduler_pkg::*;
(
    input  logic       i_clk28,
    input  logic       i_rst,
    input  logic       i_slot_free,
    input  logic       i_win_open,
    input  logic       i_req,
    input  logic [5:0] i_addr,
    output logic       o_write_req,
    output logic [5:0] o_write_addr,
    output logic       o_busy,
    output logic       o_overflow,
    output upw_state_t o_state
);

    localparam int WCW = (UPW_LEN > 1) ? $clog2(UPW_LEN) : 1;

    upw_state_t     r_state;
    logic [WCW-1:0] r_wcnt;
    logic           r_write_req;
    logic [5:0]     r_addr;
    logic           r_busy;
    logic           r_overflow;

    // i_req is a one-cycle pulse with no back-pressure: it is taken only in
    // IDLE; in any other state it is dropped and recorded in r_overflow.
    always_ff @(posedge i_clk28) begin
        if (i_rst) begin
            r_state     <= UPW_IDLE;
            r_wcnt      <= '0;
            r_write_req <= 1'b0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (i_req && (r_state != UPW_IDLE)) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                UPW_IDLE: begin
                    if (i_req) begin
                        r_addr  <= i_addr;
                        r_busy  <= 1'b1;
                        r_state <= UPW_PEND;
                    end
                end
                UPW_PEND: begin
                    if (i_slot_free) begin
                        r_wcnt      <= '0;
                        r_write_req <= 1'b1;
                        r_state     <= UPW_WRITE;
                    end
                end
                UPW_WRITE: begin
                    if (r_wcnt == WCW'(UPW_LEN - 1)) begin
                        r_write_req <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= UPW_IDLE;
                    end else if (i_win_open) begin
                        r_write_req <= 1'b0;
                        r_state     <= UPW_PEND;
                    end else begin
                        r_wcnt <= r_wcnt + WCW'(1);
                    end
                end
                default: begin
                    r_write_req <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= UPW_IDLE;
                end
            endcase
        end
    end

    assign o_write_req  = r_write_req;
    assign o_write_addr = r_addr;
    assign o_busy       = r_busy;
    assign o_overflow   = r_overflow;
    assign o_state      = r_state;

endmodule

// File: rtl/vram_scheduler.sv
// Per-clk28 SRAM time-slot scheduler: bitmap/attribute/palette fetch windows,
// video latch strobes, snow qualifier and the buffered palette write port.
module vram_scheduler
    import vram_scheduler_pkg::*;
(
    input  logic       i_clk28,
    input  logic       i_rst,
    input  logic       i_cell_sync,
    input  logic       i_scr_active,
    input  logic       i_up_active,
    input  logic       i_snow_en,
    input  logic       i_mreq,
    input  logic       i_rfsh,
    input  logic [1:0] i_a_hi,
    input  logic       i_upw_req,
    input  logic [5:0] i_upw_addr,
    output logic       o_screen_fetch,
    output logic       o_screen_fetch_up,
    output logic       o_fetch_attr,
    output logic       o_snow,
    output logic       o_latch_bmp,
    output logic       o_latch_atr,
    output logic       o_latch_up,
    output logic       o_up_write_req,
    output logic [5:0] o_up_write_addr,
    output logic       o_upw_busy,
    output logic       o_upw_overflow,
    output upw_state_t o_upw_state
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_scr;
    logic             r_up;
    logic             r_screen_fetch;
    logic             r_fetch_up;
    logic             r_fetch_attr;
    logic             r_latch_bmp;
    logic             r_latch_atr;
    logic             r_latch_up;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_scr_eff;
    logic             w_up_eff;
    logic             w_bmp_nxt;
    logic             w_atr_nxt;
    logic             w_up_nxt;
    logic             w_fetch_nxt;
    logic             w_slot_free;

    assign w_cnt_nxt = (i_cell_sync || (r_cnt == CNT_W'(CELL_LEN - 1))) ? '0 : r_cnt + CNT_W'(1);

    // Window flags are evaluated on the next counter value so the registered
    // outputs line up with the cycle the counter enters each window.
    assign w_scr_eff   = (w_cnt_nxt == '0) ? i_scr_active : r_scr;
    assign w_up_eff    = (w_cnt_nxt == '0) ? i_up_active  : r_up;
    assign w_bmp_nxt   = w_scr_eff && in_window(w_cnt_nxt, BMP_SLOT);
    assign w_atr_nxt   = w_scr_eff && in_window(w_cnt_nxt, ATR_SLOT);
    assign w_up_nxt    = w_up_eff  && in_window(w_cnt_nxt, UP_SLOT);
    assign w_fetch_nxt = w_bmp_nxt || w_atr_nxt || w_up_nxt;
    assign w_slot_free = !w_fetch_nxt && !i_mreq;

    always_ff @(posedge i_clk28) begin
        if (i_rst) begin
            r_cnt          <= '0;
            r_scr          <= 1'b0;
            r_up           <= 1'b0;
            r_screen_fetch <= 1'b0;
            r_fetch_up     <= 1'b0;
            r_fetch_attr   <= 1'b0;
            r_latch_bmp    <= 1'b0;
            r_latch_atr    <= 1'b0;
            r_latch_up     <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_scr          <= w_scr_eff;
            r_up           <= w_up_eff;
            r_screen_fetch <= w_fetch_nxt;
            r_fetch_up     <= w_up_nxt;
            r_fetch_attr   <= w_atr_nxt;
            r_latch_bmp    <= w_scr_eff && is_last(w_cnt_nxt, BMP_SLOT);
            r_latch_atr    <= w_scr_eff && is_last(w_cnt_nxt, ATR_SLOT);
            r_latch_up     <= w_up_eff  && is_last(w_cnt_nxt, UP_SLOT);
        end
    end

    vram_upw_buffer u_upw (
        .i_clk28      (i_clk28),
        .i_rst        (i_rst),
        .i_slot_free  (w_slot_free),
        .i_win_open   (w_fetch_nxt),
        .i_req        (i_upw_req),
        .i_addr       (i_upw_addr),
        .o_write_req  (o_up_write_req),
        .o_write_addr (o_up_write_addr),
        .o_busy       (o_upw_busy),
        .o_overflow   (o_upw_overflow),
        .o_state      (o_upw_state)
    );

    assign o_screen_fetch    = r_screen_fetch;
    assign o_screen_fetch_up = r_fetch_up;
    assign o_fetch_attr      = r_fetch_attr;
    assign o_latch_bmp       = r_latch_bmp;
    assign o_latch_atr       = r_latch_atr;
    assign o_latch_up        = r_latch_up;
    assign o_snow = i_snow_en && r_screen_fetch && !r_fetch_up && i_mreq && i_rfsh
                    && (i_a_hi == 2'b01);

endmodule

// File: doc/vram_scheduler.md
Name: vram_scheduler

Overview:
- Time-slot scheduler for the shared 512K video/main SRAM (va/vd).
- Decides, per clk28 cycle, whether the SRAM address mux serves a screen bitmap fetch, an attribute fetch, a ULA+ palette fetch, a buffered ULA+ palette write, or the CPU.
- Produces the screen_fetch / screen_fetch_up / up_write_req / snow qualifiers consumed by memcontrol, plus latch strobes for the video pipeline.

Parameters:
- CELL_LEN, 32, clk28 cycles per 8-pixel character cell (slot counter modulus).
- FETCH_LEN, 4, cycles one fetch owns the SRAM; data valid on its last cycle.
- BMP_SLOT, 0, cell cycle where the bitmap fetch starts.
- ATR_SLOT, 4, cell cycle where the attribute fetch starts.
- UP_SLOT, 8, cell cycle where the ULA+ palette fetch starts.
- UPW_LEN, 2, cycles a palette write holds up_write_req.

Ports:
- clk28  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cell_sync  in  1  one-cycle pulse: next cycle is cell cycle 0
- scr_active  in  1  current cell is in the paper area (bitmap+attr needed)
- up_active  in  1  ULA+ enabled; palette fetch needed this cell
- snow_en  in  1  machine model exhibits snow
- mreq  in  1  CPU memory request
- rfsh  in  1  CPU refresh cycle
- a_hi  in  2  CPU address[15:14]
- upw_req  in  1  one-cycle palette write request from port logic
- upw_addr  in  6  palette index for the write
- screen_fetch  out  1  SRAM owned by video this cycle
- screen_fetch_up  out  1  qualifies screen_fetch as a palette fetch
- fetch_attr  out  1  qualifies screen_fetch as an attribute fetch
- snow  out  1  video address low byte taken from CPU bus
- latch_bmp  out  1  bitmap byte valid on vd this cycle
- latch_atr  out  1  attribute byte valid on vd
- latch_up  out  1  palette byte valid on vd
- up_write_req  out  1  SRAM owned by the palette write
- up_write_addr  out  6  palette write index
- upw_busy  out  1  palette write buffer occupied
- upw_overflow  out  1  sticky: request arrived while busy

Behaviour:
- Reset: every output 0; cell counter 0; write buffer empty; overflow cleared.
- Cell counter:
  - 5-bit, increments each clk28 and wraps CELL_LEN-1 -> 0.
  - cell_sync forces counter to 0 on the next cycle, overriding the increment.
  - A cell_sync arriving mid-fetch aborts that fetch: no latch strobe, outputs drop the next cycle.
- Fetch windows:
  - scr_active and counter in [BMP_SLOT, BMP_SLOT+FETCH_LEN) -> screen_fetch=1, fetch_attr=0.
  - scr_active and counter in the ATR window -> screen_fetch=1, fetch_attr=1.
  - up_active and counter in the UP window -> screen_fetch=1, screen_fetch_up=1. This window is independent of scr_active.
  - scr_active and up_active are sampled at counter==0 and held for the whole cell.
- Latch strobes: one-cycle pulse on the final cycle of each window (cycles 3, 7 and 11 with defaults).
- Outputs are registered: screen_fetch rises on the clk28 edge where the counter enters the window.
- Snow:
  - Computed combinationally: snow = snow_en & screen_fetch & ~screen_fetch_up & mreq & rfsh & (a_hi==2'b01).
  - Meaningful only during bitmap/attr windows.
- Palette write path:
  - States IDLE, PEND, WRITE.
  - IDLE: upw_req -> capture upw_addr, go to PEND, upw_busy=1.
  - PEND: move to WRITE on the first cycle where the next counter value is outside all active fetch windows and mreq=0.
  - WRITE: up_write_req=1 for exactly UPW_LEN cycles, then IDLE with upw_busy=0.
  - A fetch window opening during WRITE has priority: up_write_req drops immediately and the FSM returns to PEND. up_write_addr is retained and the write is retried in full.
  - upw_req while upw_busy: request ignored, upw_overflow set; cleared only by rst.
  - upw_req in the same cycle WRITE completes: treated as busy (ignored, overflow set).
- Invariant: screen_fetch and up_write_req are never both 1.
- Reset mid-operation: the pending palette write is discarded.

Decomposition:
- Shared package common: slot constants (BMP/ATR/UP start, FETCH_LEN) and an enum upw_state_t {UPW_IDLE, UPW_PEND, UPW_WRITE}.
- Natural sub-module vram_upw_buffer: the palette-write FSM plus capture register. Inputs are a "slot free" signal and the request; outputs are up_write_req, up_write_addr, upw_busy and upw_overflow.

Test Plan:
- Reset, then free-run, scr_active=1, up_active=0, with defaults -> screen_fetch high cycles 0-7; fetch_attr high cycles 4-7; latch_bmp at 3; latch_atr at 7; nothing else in the cell.
- scr_active=0, up_active=1 -> screen_fetch and screen_fetch_up high cycles 8-11 only; latch_up at 11.
- upw_req with addr=6'h2A at cell cycle 2, mreq=0, scr_active=1 -> busy immediately. With up_active=0, up_write_req covers cycles 8-9 and up_write_addr=2A. With up_active=1 it covers cycles 12-13 instead.
- Write started at cycle 30, cell_sync pulsed so cycle 0 follows, scr_active=1 -> write aborts at the window edge, retries at cycles 8-9, and is never concurrent with screen_fetch.
- Second upw_req while busy -> upw_overflow=1; the first address is written and the second is dropped.
- snow_en=1, mreq=1, rfsh=1, a_hi=01 during the bitmap window -> snow=1. With a_hi=10, or outside any window, snow=0.
